// File: rtl/clock_timebase.sv
// Four-digit BCD timebase: a prescaler feeding a cascade of modulo digit counters with run/pause, up/down, preset load and strobes.
// Latency: digits, tick and roll are registered and change on the prescaler-advance edge; done is combinational from up and digits.
// Backpressure: none; a free-running source where pause (run=0) freezes the prescaler and digits, and load always wins.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   run, up              count enable, count direction (1 = up)
//   load, load_val[15:0] one-cycle preset strobe, preset digits {d3,d2,d1,d0}
//   digits[15:0]         current BCD digits {d3,d2,d1,d0}
//   tick, roll           one-cycle strobes: digit update, whole-chain wrap
//   done                 level: counting down, halting enabled, chain at 0000
module clock_timebase #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1,
    parameter int DIG0_MOD     = 10,
    parameter int DIG1_MOD     = 6,
    parameter int DIG2_MOD     = 10,
    parameter int DIG3_MOD     = 6,
    parameter int STOP_AT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] digits,
    output logic        tick,
    output logic        roll,
    output logic        done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    function automatic logic [3:0] dig_mod(input int i);
        case (i)
            0:       return 4'(DIG0_MOD);
            1:       return 4'(DIG1_MOD);
            2:       return 4'(DIG2_MOD);
            default: return 4'(DIG3_MOD);
        endcase
    endfunction

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic [15:0]   next_digits;
    logic [15:0]   load_sat;
    logic          chain_wrap;
    logic          carry;
    logic [3:0]    cur;
    logic [3:0]    m;
    logic [3:0]    nib;
    logic [3:0]    lm;

    assign presc_wrap = (presc == PRESC_LAST);
    assign done       = !up && (STOP_AT_ZERO != 0) && (digits == 16'h0000);

    // Ripple the carry (up) or borrow (down) from d0 upward. A digit only
    // moves while every lower digit is wrapping; a carry that survives all
    // four digits means the whole chain wrapped on this advance.
    always_comb begin
        next_digits = digits;
        carry       = 1'b1;
        cur         = 4'd0;
        m           = 4'd0;
        for (int i = 0; i < 4; i++) begin
            cur = digits[i*4 +: 4];
            m   = dig_mod(i);
            if (carry) begin
                if (up) begin
                    if (cur == m - 4'd1) begin
                        next_digits[i*4 +: 4] = 4'd0;
                    end else begin
                        next_digits[i*4 +: 4] = cur + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (cur == 4'd0) begin
                        next_digits[i*4 +: 4] = m - 4'd1;
                    end else begin
                        next_digits[i*4 +: 4] = cur - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        chain_wrap = carry;
    end

    // Preset nibbles outside a digit's range are clamped to its top value
    // so the chain never holds an illegal digit.
    always_comb begin
        load_sat = 16'h0000;
        nib      = 4'd0;
        lm       = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = load_val[i*4 +: 4];
            lm  = dig_mod(i);
            load_sat[i*4 +: 4] = (nib >= lm) ? (lm - 4'd1) : nib;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            digits <= 16'h0000;
            tick   <= 1'b0;
            roll   <= 1'b0;
        end else begin
            tick <= 1'b0;
            roll <= 1'b0;
            if (load) begin
                digits <= load_sat;
                presc  <= '0;
            end else if (run) begin
                if (presc_wrap) begin
                    presc <= '0;
                    // Halted at zero: the prescaler keeps its rhythm but
                    // the advance is swallowed.
                    if (!done) begin
                        digits <= next_digits;
                        tick   <= 1'b1;
                        roll   <= chain_wrap;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_timebase.sv
module tb_clock_timebase;

    typedef struct {
        logic [15:0] dig;
        logic        roll;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run_a, up_a, load_a;
    logic [15:0] load_val_a;
    logic [15:0] digits_a;
    logic        tick_a, roll_a, done_a;
    logic        run_b, up_b, load_b;
    logic [15:0] load_val_b;
    logic [15:0] digits_b;
    logic        tick_b, roll_b, done_b;

    int   tests;
    int   fails;
    int   cyc;
    exp_t qa[$];
    exp_t qb[$];
    logic prev_a, prev_b;

    clock_timebase #(.CLK_HZ(4), .TICK_HZ(1), .STOP_AT_ZERO(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run_a), .up(up_a), .load(load_a),
        .load_val(load_val_a), .digits(digits_a), .tick(tick_a),
        .roll(roll_a), .done(done_a)
    );

    clock_timebase #(.CLK_HZ(4), .TICK_HZ(1), .STOP_AT_ZERO(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run_b), .up(up_b), .load(load_b),
        .load_val(load_val_b), .digits(digits_b), .tick(tick_b),
        .roll(roll_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic r, input int c);
        exp_t e;
        e.dig  = d;
        e.roll = r;
        e.cyc  = c;
        return e;
    endfunction

    // Scoreboard monitors: every tick must match the oldest expected update,
    // including the cycle it was due on.
    always @(negedge clk) begin
        exp_t e;
        if (tick_a === 1'b1) begin
            tests++;
            if (prev_a === 1'b1) begin
                fails++;
                $display("FAIL a_tick_b2b: tick high two cycles running at cycle %0d", cyc);
            end
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected_tick: digits %h roll %b at cycle %0d", digits_a, roll_a, cyc);
            end else begin
                e = qa.pop_front();
                if (digits_a !== e.dig || roll_a !== e.roll || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL a_tick: got %h roll %b cycle %0d, expected %h roll %b cycle %0d",
                             digits_a, roll_a, cyc, e.dig, e.roll, e.cyc);
                end
            end
        end else if (roll_a === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL a_roll_no_tick: roll high without tick at cycle %0d", cyc);
        end
        prev_a = tick_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (tick_b === 1'b1) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected_tick: digits %h roll %b at cycle %0d", digits_b, roll_b, cyc);
            end else begin
                e = qb.pop_front();
                if (digits_b !== e.dig || roll_b !== e.roll || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL b_tick: got %h roll %b cycle %0d, expected %h roll %b cycle %0d",
                             digits_b, roll_b, cyc, e.dig, e.roll, e.cyc);
                end
            end
        end else if (roll_b === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL b_roll_no_tick: roll high without tick at cycle %0d", cyc);
        end
        prev_b = tick_b;
    end

    initial begin
        int c;
        tests = 0;
        fails = 0;
        prev_a = 1'b0;
        prev_b = 1'b0;
        rst_n = 1'b0;
        run_a = 1'b0; up_a = 1'b1; load_a = 1'b0; load_val_a = 16'h0000;
        run_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = 16'h0000;

        // Reset state
        step(2);
        chk("rst_digits", digits_a, 16'h0000);
        chk("rst_tick", {15'd0, tick_a}, 16'h0000);
        chk("rst_roll", {15'd0, roll_a}, 16'h0000);
        chk("rst_done_up", {15'd0, done_a}, 16'h0000);
        up_a = 1'b0;
        #1;
        chk("rst_done_down", {15'd0, done_a}, 16'h0001);
        chk("rst_done_nostop", {15'd0, done_b}, 16'h0000);
        up_a = 1'b1;

        // Prescale: first tick on the 4th edge after release, then every 4
        rst_n = 1'b1;
        run_a = 1'b1;
        c = cyc;
        qa.push_back(mk(16'h0001, 1'b0, c + 4));
        qa.push_back(mk(16'h0002, 1'b0, c + 8));
        qa.push_back(mk(16'h0003, 1'b0, c + 12));
        step(12);

        // Up rollover of the whole chain
        c = cyc;
        load_a = 1'b1; load_val_a = 16'h5959;
        qa.push_back(mk(16'h0000, 1'b1, c + 5));
        step(1);
        load_a = 1'b0;
        chk("load_5959", digits_a, 16'h5959);
        chk("load_tick", {15'd0, tick_a}, 16'h0000);
        step(4);

        // Cascade without full wrap
        c = cyc;
        load_a = 1'b1; load_val_a = 16'h0959;
        qa.push_back(mk(16'h1000, 1'b0, c + 5));
        step(1);
        load_a = 1'b0;
        step(4);

        // Down count to zero and halt
        c = cyc;
        load_a = 1'b1; load_val_a = 16'h0002; up_a = 1'b0;
        qa.push_back(mk(16'h0001, 1'b0, c + 5));
        qa.push_back(mk(16'h0000, 1'b0, c + 9));
        step(1);
        load_a = 1'b0;
        chk("load_0002", digits_a, 16'h0002);
        chk("done_before_zero", {15'd0, done_a}, 16'h0000);
        step(8);
        chk("done_at_zero", {15'd0, done_a}, 16'h0001);
        step(20);
        chk("held_zero", digits_a, 16'h0000);
        chk("done_held", {15'd0, done_a}, 16'h0001);
        up_a = 1'b1;
        qa.push_back(mk(16'h0001, 1'b0, c + 33));
        step(4);
        chk("done_cleared", {15'd0, done_a}, 16'h0000);

        // Pause for 10 cycles with prescaler at 2; phase is kept
        step(2);
        c = cyc;
        run_a = 1'b0;
        step(10);
        chk("paused_digits", digits_a, 16'h0001);
        run_a = 1'b1;
        qa.push_back(mk(16'h0002, 1'b0, c + 12));
        step(2);

        // Load on an advance edge wins; out-of-range nibbles saturate
        step(3);
        c = cyc;
        load_a = 1'b1; load_val_a = 16'h7A3F;
        step(1);
        load_a = 1'b0;
        chk("load_sat", digits_a, 16'h5939);
        chk("load_coll_tick", {15'd0, tick_a}, 16'h0000);
        qa.push_back(mk(16'h5940, 1'b0, c + 5));
        step(4);

        // Mid-run reset with prescaler at 2
        c = cyc;
        load_a = 1'b1; load_val_a = 16'h0123;
        step(1);
        load_a = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("midrst_digits", digits_a, 16'h0000);
        chk("midrst_tick", {15'd0, tick_a}, 16'h0000);
        rst_n = 1'b1;
        qa.push_back(mk(16'h0001, 1'b0, c + 8));
        step(4);
        run_a = 1'b0;

        // Down wrap with halting disabled
        c = cyc;
        load_b = 1'b1; load_val_b = 16'h0000; up_b = 1'b0; run_b = 1'b1;
        qb.push_back(mk(16'h5959, 1'b1, c + 5));
        qb.push_back(mk(16'h5958, 1'b0, c + 9));
        step(1);
        load_b = 1'b0;
        chk("b_done_nostop", {15'd0, done_b}, 16'h0000);
        step(8);
        run_b = 1'b0;

        step(2);
        chk("a_all_ticks_seen", 16'(qa.size()), 16'h0000);
        chk("b_all_ticks_seen", 16'(qb.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
